// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with valid/ready handshake,
// a DEPTH-entry circular buffer, flush/stall control and a bubble value
// presented while the stage is empty.
// Build option: define PIPE_STAGE_BUF_REG_EN for the registered buffer;
// with it undefined the block is a flop-free combinational pass-through.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DEPTH       = 2,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h13),
  localparam int unsigned      CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic              out_flushed_o,
  output logic [CNT_W-1:0]  count_o
);

  // Reject unsupported buffer depths at elaboration time.
  generate
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be in the range 1..8");
    end
  endgenerate

`ifdef PIPE_STAGE_BUF_REG_EN

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = DATA_W + CTRL_W;

  // Each entry stores {ctrl, data}; only entries between rd_ptr and wr_ptr are live.
  logic [ENT_W-1:0] mem_reg [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             flushed_reg, flushed_next;
  logic             not_full;
  logic             push;
  logic             pop;

  // Advance a pointer, wrapping from DEPTH-1 back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // A full stage can still take a beat when the head leaves in the same cycle;
  // during flush upstream is always allowed to drain into the discard.
  assign not_full    = (count_reg != CNT_W'(DEPTH));
  assign in_ready_o  = flush_i | (!stall_i & (not_full | out_ready_i));
  assign out_valid_o = (count_reg != '0);
  assign push        = in_valid_i & in_ready_o & !flush_i;
  assign pop         = out_valid_o & out_ready_i & !stall_i & !flush_i;

  // Next-state for pointers, occupancy and the flush pulse (flush beats stall).
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    flushed_next = 1'b0;
    if (flush_i) begin
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
      flushed_next = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      flushed_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      flushed_reg <= flushed_next;
    end
  end

  // Payload storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {in_ctrl_i, in_data_i};
    end
  end

  // Present the head entry, or the bubble with cleared control when empty.
  always_comb begin
    out_data_o = BUBBLE_DATA;
    out_ctrl_o = '0;
    if (out_valid_o) begin
      {out_ctrl_o, out_data_o} = mem_reg[rd_ptr_reg];
    end
  end

  assign count_o       = count_reg;
  assign out_flushed_o = flushed_reg;

`else

  // Pass-through build: no storage, flush squashes the beat in flight.
  assign out_valid_o   = in_valid_i & !flush_i;
  assign out_data_o    = flush_i ? BUBBLE_DATA : in_data_i;
  assign out_ctrl_o    = flush_i ? '0 : in_ctrl_i;
  assign in_ready_o    = out_ready_i & !stall_i;
  assign count_o       = '0;
  assign out_flushed_o = 1'b0;

  // Clock and reset have no loads in this build.
  logic unused_pass;
  assign unused_pass = &{1'b0, clk, rst_n};

`endif

endmodule
